// File: rtl/demux_steer_ctrl.sv
// Steering scheduler for the 1:2 byte demux: bursts words over two lanes,
// skips almost-full lanes, and backpressures upstream when both are blocked.
module demux_steer_ctrl #(
    parameter int BURST  = 4,
    parameter int CNT_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              almost_full0,
    input  logic              almost_full1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              selector,
    output logic              pause,
    output logic              overflow,
    output logic [CNT_W-1:0]  count0,
    output logic [CNT_W-1:0]  count1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [7:0] BURST_L = 8'(BURST);

    state_t     state, state_nxt;
    logic       lane, lane_nxt;
    logic [7:0] burst_cnt, burst_cnt_nxt;
    logic       word_acc;
    logic       tgt;
    logic [7:0] cnt_inc;
    logic       both_blk;
    logic       cur_blk;
    logic       tgt_other_blk;
    logic       lane_other_blk;

    assign both_blk       = almost_full0 & almost_full1;
    assign cur_blk        = lane ? almost_full1 : almost_full0;
    assign lane_other_blk = lane ? almost_full0 : almost_full1;
    assign tgt_other_blk  = tgt  ? almost_full0 : almost_full1;

    // A blocked current lane diverts the word to the other lane and restarts the burst there
    always_comb begin
        if (!cur_blk) begin
            tgt     = lane;
            cnt_inc = burst_cnt + 8'd1;
        end else begin
            tgt     = ~lane;
            cnt_inc = 8'd1;
        end
    end

    always_comb begin
        state_nxt     = state;
        lane_nxt      = lane;
        burst_cnt_nxt = burst_cnt;
        word_acc      = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    if (both_blk) state_nxt = STALL;
                    else          word_acc  = 1'b1;
                end
            end
            SEND: begin
                if (both_blk)      state_nxt = STALL;
                else if (valid_in) word_acc  = 1'b1;
            end
            STALL: begin
                if (!both_blk) begin
                    state_nxt     = SEND;
                    lane_nxt      = lane_other_blk ? lane : ~lane;
                    burst_cnt_nxt = 8'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Burst completion alternates lanes unless the other lane is full
        if (word_acc) begin
            state_nxt = SEND;
            if (cnt_inc == BURST_L) begin
                lane_nxt      = tgt_other_blk ? tgt : ~tgt;
                burst_cnt_nxt = 8'd0;
            end else begin
                lane_nxt      = tgt;
                burst_cnt_nxt = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lane      <= 1'b0;
            burst_cnt <= 8'd0;
            data_out  <= '0;
            valid_out <= 1'b0;
            selector  <= 1'b0;
            pause     <= 1'b0;
            overflow  <= 1'b0;
            count0    <= '0;
            count1    <= '0;
        end else begin
            state     <= state_nxt;
            lane      <= lane_nxt;
            burst_cnt <= burst_cnt_nxt;
            valid_out <= word_acc;
            pause     <= (state_nxt == STALL);
            if (word_acc) begin
                data_out <= data_in;
                selector <= tgt;
                if (tgt) count1 <= count1 + CNT_W'(1);
                else     count0 <= count0 + CNT_W'(1);
            end
            // Upstream ignored backpressure: the word is lost
            if (valid_in && state == STALL) overflow <= 1'b1;
        end
    end

endmodule
